// File: rtl/fp_add_scheduler_pkg.sv
// fp_sched_pkg: shared defaults, op encoding and tag type for the FP add/sub scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: N_REQ_DEF/FP_W_DEF/LAT_DEF defaults, OP_ADD/OP_SUB encodings, tag_t for the in-flight tag pipeline.
package fp_sched_pkg;

  localparam int N_REQ_DEF = 4;   // requesters sharing the unit (2..8)
  localparam int FP_W_DEF  = 24;  // operand/result width
  localparam int LAT_DEF   = 2;   // shared unit pipeline depth

  // Requester id width sized for the largest supported N_REQ (8).
  localparam int ID_W = 3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One entry of the in-flight tracking pipeline: which requester owns the
  // result that will emerge from the shared unit.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_add_scheduler_if.sv
// fp_add_scheduler_if: request, shared-unit and response signals of the FP add/sub scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_ready is the one-hot grant; responses are never stalled.
// Modports: slave = scheduler side, master = requesters + shared unit side.
// Optional: req_op exists only when FP_SCHED_OP_SEL_EN is defined.
interface fp_add_scheduler_if
  import fp_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int FP_W  = FP_W_DEF
);

  // Requester side
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
`ifdef FP_SCHED_OP_SEL_EN
  logic [N_REQ-1:0]      req_op;
`endif
  logic [N_REQ-1:0]      req_ready;
  logic                  hold;

  // Shared add/sub unit side
  logic [FP_W-1:0]       arith_a;
  logic [FP_W-1:0]       arith_b;
  logic                  arith_op;
  logic [FP_W-1:0]       arith_z;

  // Response side
  logic [N_REQ-1:0]      rsp_valid;
  logic [FP_W-1:0]       rsp_data;
  logic                  busy;

  modport slave (
`ifdef FP_SCHED_OP_SEL_EN
    input  req_op,
`endif
    input  req_valid, req_a, req_b, hold, arith_z,
    output req_ready, arith_a, arith_b, arith_op, rsp_valid, rsp_data, busy
  );

  modport master (
`ifdef FP_SCHED_OP_SEL_EN
    output req_op,
`endif
    output req_valid, req_a, req_b, hold, arith_z,
    input  req_ready, arith_a, arith_b, arith_op, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one requester, searching upward from ptr with wrap.
// Latency: 0 cycles (pure combinational); the pointer register lives in the parent.
// Backpressure: none; masking (hold) is applied to req by the parent.
// Ports: req/ptr in; grant (one-hot), gnt_idx, gnt_vld, nxt_ptr = (winner+1) mod N_REQ out.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] gnt_idx,
  output logic [PTR_W-1:0] nxt_ptr,
  output logic             gnt_vld
);

  // Two passes with constant indices: first the requesters at or above ptr,
  // then (only if none found) the lowest requester overall, which must lie
  // below ptr. Together this is an ascending search from ptr with wrap.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    nxt_ptr = ptr;
    gnt_vld = 1'b0;

    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_vld && req[i] && (PTR_W'(i) >= ptr)) begin
        grant[i] = 1'b1;
        gnt_idx  = PTR_W'(i);
        nxt_ptr  = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
        gnt_vld  = 1'b1;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_vld && req[i]) begin
        grant[i] = 1'b1;
        gnt_idx  = PTR_W'(i);
        nxt_ptr  = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin issue of N_REQ requesters onto one external FP add/sub unit.
// Latency: LAT+2 cycles grant->rsp_valid; throughput one operation per cycle.
// Backpressure: req_ready is the combinational one-hot grant (zero under hold/reset); responses cannot stall.
// Ports: clock, reset_n (async, active-low), bus = fp_add_scheduler_if.slave.
// Optional: FP_SCHED_OP_SEL_EN adds req_op and forwards the granted op on arith_op; otherwise add only.
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int FP_W  = FP_W_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  fp_add_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0] ptr_q,       ptr_d;
  logic [FP_W-1:0]  arith_a_q,   arith_a_d;
  logic [FP_W-1:0]  arith_b_q,   arith_b_d;
  logic             arith_op_q,  arith_op_d;
  tag_t             tag_q [LAT+1];
  tag_t             tag_d [LAT+1];
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [FP_W-1:0]  rsp_data_q,  rsp_data_d;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] nxt_ptr;
  logic             gnt_vld;

  // hold removes every request from the search, so no grant and no pointer move.
  assign arb_req = bus.req_valid & {N_REQ{~bus.hold}};

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req     (arb_req),
    .ptr     (ptr_q),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .nxt_ptr (nxt_ptr),
    .gnt_vld (gnt_vld)
  );

  // Gated with reset_n directly so no requester sees a transfer while the
  // block is held in reset.
  assign bus.req_ready = grant & {N_REQ{reset_n}};

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    ptr_d       = ptr_q;
    arith_a_d   = arith_a_q;
    arith_b_d   = arith_b_q;
`ifdef FP_SCHED_OP_SEL_EN
    arith_op_d  = arith_op_q;
`else
    arith_op_d  = OP_ADD;
`endif
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    if (gnt_vld) begin
      ptr_d = nxt_ptr;
    end

    // Operand mux driven by the one-hot grant; registers hold their value
    // when nothing is granted.
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        arith_a_d = bus.req_a[i*FP_W +: FP_W];
        arith_b_d = bus.req_b[i*FP_W +: FP_W];
`ifdef FP_SCHED_OP_SEL_EN
        arith_op_d = bus.req_op[i];
`endif
      end
    end

    // Tag pipeline: stage 0 is loaded alongside the operand registers, so
    // stage LAT lines up with arith_z for the same operation.
    tag_d[0].vld = gnt_vld;
    tag_d[0].id  = ID_W'(gnt_idx);
    for (int i = 1; i <= LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    // Response stage: capture the unit result for the emerging tag only.
    if (tag_q[LAT].vld) begin
      rsp_data_d = bus.arith_z;
    end
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid_d[i] = tag_q[LAT].vld && (tag_q[LAT].id == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      arith_a_q   <= '0;
      arith_b_q   <= '0;
      arith_op_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      arith_a_q   <= arith_a_d;
      arith_b_q   <= arith_b_d;
      arith_op_q  <= arith_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int i = 0; i <= LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic tags_busy;

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      tags_busy = tags_busy | tag_q[i].vld;
    end
  end

  assign bus.arith_a   = arith_a_q;
  assign bus.arith_b   = arith_b_q;
  assign bus.arith_op  = arith_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = tags_busy | (|rsp_valid_q);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: directed and randomized checks of fp_add_scheduler against a cycle-schedule model.
// Latency: expects responses LAT+2 cycles after each grant.
// Backpressure: requesters hold operands until granted; responses consumed unconditionally.
module tb_fp_add_scheduler;
  import fp_sched_pkg::*;

  localparam int N   = 4;
  localparam int W   = 24;
  localparam int LAT = 2;

  logic clock;
  logic reset_n;

  fp_add_scheduler_if #(.N_REQ(N), .FP_W(W)) bus ();

  fp_add_scheduler #(.N_REQ(N), .FP_W(W), .LAT(LAT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------------------------------------------------------------
  // 24-bit float (1/8/15) arithmetic through IEEE double
  // ---------------------------------------------------------------------
  function automatic real fp_to_real(logic [23:0] x);
    logic [63:0] d;
    if (x[22:15] == 8'd0) return 0.0;
    d = {x[23], ({3'b000, x[22:15]} + 11'd896), x[14:0], 37'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [23:0] real_to_fp(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 24'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:37]};
  endfunction

  function automatic logic [23:0] fp_op(logic [23:0] a, logic [23:0] b, logic op);
    real ra;
    real rb;
    ra = fp_to_real(a);
    rb = fp_to_real(b);
    return real_to_fp(op ? (ra - rb) : (ra + rb));
  endfunction

  function automatic logic [23:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(110, 140));
    return {1'($urandom_range(0, 1)), e, 15'($urandom)};
  endfunction

  // ---------------------------------------------------------------------
  // Shared add/sub unit stand-in: fixed LAT-cycle pipeline
  // ---------------------------------------------------------------------
  logic [23:0] z_pipe [LAT];
  always @(posedge clock) begin
    z_pipe[0] <= fp_op(bus.arith_a, bus.arith_b, bus.arith_op);
    for (int i = 1; i < LAT; i++) z_pipe[i] <= z_pipe[i-1];
  end
  assign bus.arith_z = z_pipe[LAT-1];

  // ---------------------------------------------------------------------
  // Reference model: round-robin pick plus a schedule of responses indexed
  // by the cycle in which they must appear.
  // ---------------------------------------------------------------------
  function automatic int model_pick(logic [N-1:0] rv, logic h, int p);
    if (h) return -1;
    for (int k = 0; k < N; k++) begin
      if (rv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  int          cyc;
  int          m_ptr;
  logic        sl_vld [16];
  int          sl_id  [16];
  logic [23:0] sl_dat [16];
  logic [23:0] m_rsp_data;
  logic [23:0] m_a;
  logic [23:0] m_b;
  logic        m_op;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr = 0;
      m_rsp_data = '0;
      m_a = '0;
      m_b = '0;
      m_op = 1'b0;
      for (int s = 0; s < 16; s++) sl_vld[s] = 1'b0;
    end else begin
      int g;
      logic o;
      g = model_pick(bus.req_valid, bus.hold, m_ptr);
      sl_vld[cyc % 16] = 1'b0;
      if (g >= 0) begin
        o = 1'b0;
`ifdef FP_SCHED_OP_SEL_EN
        o = bus.req_op[g];
`endif
        m_a = bus.req_a[g*W +: W];
        m_b = bus.req_b[g*W +: W];
        m_op = o;
        sl_vld[(cyc + LAT + 2) % 16] = 1'b1;
        sl_id[(cyc + LAT + 2) % 16]  = g;
        sl_dat[(cyc + LAT + 2) % 16] = fp_op(m_a, m_b, o);
        m_ptr = (g + 1) % N;
      end
      cyc = cyc + 1;
      if (sl_vld[cyc % 16]) m_rsp_data = sl_dat[cyc % 16];
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic set_req(int r, logic [23:0] a, logic [23:0] b);
    bus.req_a[r*W +: W] = a;
    bus.req_b[r*W +: W] = b;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.hold = 1'b0;
`ifdef FP_SCHED_OP_SEL_EN
    bus.req_op = '0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drain(int n);
    clear_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.hold = 1'b0;
    sample();
    n_chk++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); else n_pass++;
    n_chk++; if (bus.rsp_data !== 24'h0) $display("FAIL reset_rsp_data: got %h want 000000", bus.rsp_data); else n_pass++;
    n_chk++; if ({bus.arith_a, bus.arith_b, bus.arith_op} !== 49'h0) $display("FAIL reset_arith: got a=%h b=%h op=%b want 0", bus.arith_a, bus.arith_b, bus.arith_op); else n_pass++;
    tick();
    clear_inputs();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 24'h3F8000, 24'h3F8000);
    bus.req_valid = 4'b0001;
    sample();
    n_chk++; if (bus.req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", bus.req_ready); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.req_valid = '0;
      sample();
      if (k == 1) begin
        n_chk++; if (bus.arith_a !== 24'h3F8000 || bus.arith_b !== 24'h3F8000) $display("FAIL single_arith: got a=%h b=%h want 3f8000", bus.arith_a, bus.arith_b); else n_pass++;
      end
      if (k < 4) begin
        n_chk++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1) $display("FAIL single_early k=%0d: got rsp=%b busy=%b want 0000/1", k, bus.rsp_valid, bus.busy); else n_pass++;
      end else begin
        n_chk++; if (bus.rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid: got %b want 0001", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_data !== 24'h400000) $display("FAIL single_rsp_data: got %h want 400000", bus.rsp_data); else n_pass++;
      end
    end
    tick();
    sample();
    n_chk++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 24'h400000 || bus.busy !== 1'b0) $display("FAIL single_after: got rsp=%b data=%h busy=%b want 0000/400000/0", bus.rsp_valid, bus.rsp_data, bus.busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [23:0] ra [N];
    logic [23:0] rb [N];
    logic [23:0] ez [N];
    do_reset();
    for (int r = 0; r < N; r++) begin
      ra[r] = rand_fp();
      rb[r] = rand_fp();
      ez[r] = fp_op(ra[r], rb[r], 1'b0);
      set_req(r, ra[r], rb[r]);
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      bus.req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      sample();
      if (i < 8) begin
        n_chk++; if (bus.req_ready !== 4'(1 << (i % N))) $display("FAIL rr_grant i=%0d: got %b want %b", i, bus.req_ready, 4'(1 << (i % N))); else n_pass++;
      end
      if (i >= 4) begin
        n_chk++; if (bus.rsp_valid !== 4'(1 << ((i - 4) % N)) || bus.rsp_data !== ez[(i - 4) % N]) $display("FAIL rr_rsp i=%0d: got %b/%h want %b/%h", i, bus.rsp_valid, bus.rsp_data, 4'(1 << ((i - 4) % N)), ez[(i - 4) % N]); else n_pass++;
      end
    end
    drain(4);
  endtask

  task automatic test_wrap();
    set_req(0, 24'h3F8000, 24'h400000);
    set_req(2, 24'h404000, 24'h3F8000);
    bus.req_valid = 4'b0100;
    sample();
    n_chk++; if (bus.req_ready !== 4'b0100) $display("FAIL wrap_first: got %b want 0100", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 4'b0101;
    sample();
    n_chk++; if (bus.req_ready !== 4'b0001) $display("FAIL wrap_second: got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 4'b0101;
    sample();
    n_chk++; if (bus.req_ready !== 4'b0100) $display("FAIL wrap_third: got %b want 0100", bus.req_ready); else n_pass++;
    drain(6);
  endtask

  task automatic test_hold();
    set_req(0, 24'h40A000, 24'h404000);
    set_req(1, 24'h3F8000, 24'h3F8000);
    bus.req_valid = 4'b0001;
    sample();
    n_chk++; if (bus.req_ready !== 4'b0001) $display("FAIL hold_pre_grant: got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    for (int h = 0; h < 3; h++) begin
      tick();
      bus.req_valid = 4'b0010;
      bus.hold = 1'b1;
      sample();
      n_chk++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) $display("FAIL hold_ready h=%0d: got rdy=%b busy=%b want 0000/1", h, bus.req_ready, bus.busy); else n_pass++;
      if (h == 2) begin
        n_chk++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 24'h410000) $display("FAIL hold_inflight: got %b/%h want 0001/410000", bus.rsp_valid, bus.rsp_data); else n_pass++;
      end
    end
    tick();
    bus.hold = 1'b0;
    sample();
    n_chk++; if (bus.req_ready !== 4'b0010) $display("FAIL hold_release: got %b want 0010", bus.req_ready); else n_pass++;
    drain(6);
  endtask

  task automatic test_reset_midop();
    set_req(0, 24'h3F8000, 24'h3F8000);
    set_req(1, 24'h404000, 24'h3F8000);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    reset_n = 1'b0;
    sample();
    n_chk++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.arith_a !== 24'h0) $display("FAIL midop_in_reset: got busy=%b rsp=%b a=%h want 0", bus.busy, bus.rsp_valid, bus.arith_a); else n_pass++;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      n_chk++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL midop_after k=%0d: got rsp=%b busy=%b want 0000/0", k, bus.rsp_valid, bus.busy); else n_pass++;
      tick();
    end
  endtask

  task automatic test_op_sel();
    logic        want_op;
    logic [23:0] want_z;
`ifdef FP_SCHED_OP_SEL_EN
    want_op = 1'b1;
    want_z  = 24'h400000;   // 5.0 - 3.0
    bus.req_op = 4'b1000;
`else
    want_op = 1'b0;
    want_z  = 24'h410000;   // 5.0 + 3.0
`endif
    set_req(3, 24'h40A000, 24'h404000);
    bus.req_valid = 4'b1000;
    sample();
    n_chk++; if (bus.req_ready !== 4'b1000) $display("FAIL opsel_grant: got %b want 1000", bus.req_ready); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      clear_inputs();
      sample();
      if (k == 1) begin
        n_chk++; if (bus.arith_op !== want_op || bus.arith_a !== 24'h40A000) $display("FAIL opsel_arith: got op=%b a=%h want %b/40a000", bus.arith_op, bus.arith_a, want_op); else n_pass++;
      end
      if (k == 4) begin
        n_chk++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== want_z) $display("FAIL opsel_rsp: got %b/%h want 1000/%h", bus.rsp_valid, bus.rsp_data, want_z); else n_pass++;
      end
    end
    drain(2);
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [23:0]  pa [N];
    logic [23:0]  pb [N];
    logic         po [N];
    int           last_g;
    int           g;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rsp;
    logic         e_busy;
    pend = '0;
    last_g = -1;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (c > 0) tick();
      if (last_g >= 0) pend[last_g] = 1'b0;
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
          pend[r] = 1'b1;
          pa[r] = rand_fp();
          pb[r] = rand_fp();
          po[r] = 1'($urandom_range(0, 1));
        end
        set_req(r, pa[r], pb[r]);
`ifdef FP_SCHED_OP_SEL_EN
        bus.req_op[r] = po[r];
`endif
      end
      bus.hold = ($urandom_range(0, 7) == 0);
      bus.req_valid = pend;
      sample();
      g = model_pick(bus.req_valid, bus.hold, m_ptr);
      e_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      e_rsp = sl_vld[cyc % 16] ? 4'(1 << sl_id[cyc % 16]) : 4'b0000;
      e_busy = sl_vld[cyc % 16] | sl_vld[(cyc + 1) % 16] | sl_vld[(cyc + 2) % 16] | sl_vld[(cyc + 3) % 16];
      n_chk++; if (bus.req_ready !== e_rdy) $display("FAIL rand_ready c=%0d: got %b want %b", c, bus.req_ready, e_rdy); else n_pass++;
      n_chk++; if (bus.rsp_valid !== e_rsp) $display("FAIL rand_rsp_valid c=%0d: got %b want %b", c, bus.rsp_valid, e_rsp); else n_pass++;
      n_chk++; if (bus.rsp_data !== m_rsp_data) $display("FAIL rand_rsp_data c=%0d: got %h want %h", c, bus.rsp_data, m_rsp_data); else n_pass++;
      n_chk++; if (bus.arith_a !== m_a || bus.arith_b !== m_b || bus.arith_op !== m_op) $display("FAIL rand_arith c=%0d: got %h/%h/%b want %h/%h/%b", c, bus.arith_a, bus.arith_b, bus.arith_op, m_a, m_b, m_op); else n_pass++;
      n_chk++; if (bus.busy !== e_busy) $display("FAIL rand_busy c=%0d: got %b want %b", c, bus.busy, e_busy); else n_pass++;
      last_g = g;
    end
    drain(6);
  endtask

  // ---------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------
  initial begin
    cyc = 0;
    m_ptr = 0;
    for (int s = 0; s < 16; s++) begin
      sl_vld[s] = 1'b0;
      sl_id[s]  = 0;
      sl_dat[s] = '0;
    end
    reset_n = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    clear_inputs();

    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_hold();
    test_reset_midop();
    test_op_sel();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/fp_add_scheduler.md
FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one FP add/sub unit (2..8).
REQ-002 Parameter: FP_W, 24, floating-point operand/result width.
REQ-003 Parameter: LAT, 2, fixed cycles from arith_a/arith_b valid to arith_z valid in the shared unit.
REQ-004 Port: clock  input  1  sole clock, rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: req_valid  input  N_REQ  per-requester operation request.
REQ-007 Port: req_a, req_b  input  N_REQ*FP_W  operands; requester i at [i*FP_W +: FP_W].
REQ-008 Port: req_op  input  N_REQ  per-requester op, 0=add, 1=sub (present only with FP_SCHED_OP_SEL_EN).
REQ-009 Port: req_ready  output  N_REQ  one-hot grant, combinational.
REQ-010 Port: hold  input  1  suppresses new grants.
REQ-011 Port: arith_a, arith_b  output  FP_W  registered operands to shared unit.
REQ-012 Port: arith_op  output  1  registered op to shared unit.
REQ-013 Port: arith_z  input  FP_W  shared unit result.
REQ-014 Port: rsp_valid  output  N_REQ  one-hot, one-cycle result strobe.
REQ-015 Port: rsp_data  output  FP_W  registered result.
REQ-016 Port: busy  output  1  high while any issued operation is in flight.

Function
REQ-017 Handshake: transfer for requester i when req_valid[i] & req_ready[i]; requester holds valid, operands and op stable until transfer.
REQ-018 Arbitration: round-robin; at most one req_ready bit per cycle; search starts at pointer ptr, ascending, wrapping N_REQ-1 -> 0.
REQ-019 After grant to g, ptr <= (g+1) mod N_REQ; with no grant, ptr unchanged.
REQ-020 hold=1: req_ready all zero, ptr unchanged, in-flight operations complete normally.
REQ-021 Grant at cycle t: arith_a/arith_b/arith_op carry granted operands from t+1; with no grant they retain previous values.
REQ-022 Tag pipeline: {valid, id} shift register of depth LAT+1; entry issued at t emerges at t+1+LAT aligned with arith_z.
REQ-023 At t+2+LAT: rsp_data <= captured arith_z, rsp_valid[id]=1 for exactly one cycle; total latency LAT+2; throughput one op per cycle.
REQ-024 rsp_valid is zero in every cycle without an emerging valid tag; rsp_data retains last value.
REQ-025 No response backpressure: requesters accept rsp_valid unconditionally.
REQ-026 busy = OR of all tag-pipeline valid bits and the response stage valid.
REQ-027 Simultaneous request from all N_REQ requesters: each served once in N_REQ consecutive cycles, in pointer order.

Reset
REQ-028 reset_n low asynchronously clears ptr to 0, all tag valids, rsp_valid, busy, arith_a, arith_b, arith_op, rsp_data to 0.
REQ-029 Reset mid-operation discards in-flight results; no rsp_valid after reset release for operations issued before reset.
REQ-030 req_ready is all zero while reset_n is low.

Configuration
REQ-031 Macro FP_SCHED_OP_SEL_EN defined: req_op port exists; arith_op = req_op of granted requester.
REQ-032 Macro undefined: req_op port absent; arith_op constant 0 (add only).

Structure
REQ-033 Package fp_sched_pkg holds FP_W default, N_REQ default, LAT default and the op encoding constants OP_ADD=0, OP_SUB=1.
REQ-034 Sub-module rr_arbiter: req vector and ptr in, one-hot grant and next-pointer out; purely combinational, ptr register in parent.
REQ-035 The shared add/sub unit is instantiated outside this block.

Verification
REQ-036 After reset, req_valid=4'b0001, a=0x3F8000, b=0x3F8000 -> req_ready=4'b0001 same cycle; rsp_valid=4'b0001 exactly LAT+2=4 cycles later, rsp_data = model sum.
REQ-037 req_valid=4'b1111 held 8 cycles from ptr=0 -> grants 0,1,2,3,0,1,2,3; responses in same order, one per cycle.
REQ-038 Requester 2 granted, then req_valid=4'b0101 -> next grant is requester 0 (wrap), then 2.
REQ-039 hold=1 for 3 cycles with req_valid=4'b0010 -> no grants, ptr unchanged; in-flight results still returned; grant to 1 on first cycle hold=0.
REQ-040 Issue 2 ops, assert reset_n low one cycle before first result -> no rsp_valid ever for those ops; busy=0 after reset.
REQ-041 With FP_SCHED_OP_SEL_EN, req_op[3]=1, a=5.0, b=3.0 -> arith_op=1 one cycle after grant, rsp_data=2.0 to requester 3; without macro arith_op stays 0.
